// File: rtl/ac_sequencer.sv
// Actuator sequencer between the heat/cool decision logic and the heater, cooler and fan drives.
// Enforces fan pre-run, minimum on-time, fan post-run and an all-off lockout between starts.
module ac_sequencer #(
  parameter int FAN_PRE  = 2,
  parameter int MIN_ON   = 4,
  parameter int FAN_POST = 3,
  parameter int MIN_OFF  = 5,
  parameter int CW       = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       heat_req,
  input  logic       cool_req,
  output logic       heater_en,
  output logic       cooler_en,
  output logic       fan_en,
  output logic       busy,
  output logic       fault,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PRE  = 3'd1,
    S_HEAT = 3'd2,
    S_COOL = 3'd3,
    S_POST = 3'd4,
    S_LOCK = 3'd5
  } state_t;

  localparam logic [CW-1:0] PRE_LAST  = CW'(FAN_PRE - 1);
  localparam logic [CW-1:0] ON_LAST   = CW'(MIN_ON - 1);
  localparam logic [CW-1:0] POST_LAST = CW'(FAN_POST - 1);
  localparam logic [CW-1:0] OFF_LAST  = CW'(MIN_OFF - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          mode_q, mode_d;     // 1 = cooling mode latched at PRE entry
  logic          heater_q, heater_d;
  logic          cooler_q, cooler_d;
  logic          fan_q, fan_d;
  logic          busy_q, busy_d;
  logic          fault_q, fault_d;

  logic heat_ok, cool_ok, mode_ok;

  // Both requests high is a fault and never counts as a valid request of either mode.
  assign heat_ok = heat_req & ~cool_req;
  assign cool_ok = cool_req & ~heat_req;
  assign mode_ok = mode_q ? cool_ok : heat_ok;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      mode_q   <= 1'b0;
      heater_q <= 1'b0;
      cooler_q <= 1'b0;
      fan_q    <= 1'b0;
      busy_q   <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mode_q   <= mode_d;
      heater_q <= heater_d;
      cooler_q <= cooler_d;
      fan_q    <= fan_d;
      busy_q   <= busy_d;
      fault_q  <= fault_d;
    end
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    unique case (state_q)
      S_IDLE: begin
        if (heat_ok || cool_ok) begin
          state_d = S_PRE;
          mode_d  = cool_ok;
        end
      end
      S_PRE: begin
        if (!mode_ok)              state_d = S_IDLE;
        else if (cnt_q == PRE_LAST) state_d = mode_q ? S_COOL : S_HEAT;
      end
      S_HEAT, S_COOL: begin
        if (cnt_q >= ON_LAST && !mode_ok) state_d = S_POST;
      end
      S_POST: if (cnt_q == POST_LAST) state_d = S_LOCK;
      S_LOCK: if (cnt_q == OFF_LAST)  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Restart at zero on any state change; saturate so a long HEAT/COOL never wraps.
    if (state_d != state_q) cnt_d = '0;
    else if (cnt_q == '1)   cnt_d = cnt_q;
    else                    cnt_d = cnt_q + 1'b1;
  end

  // Drives are decoded from the next state so they switch on the same edge as state.
  always_comb begin
    heater_d = (state_d == S_HEAT);
    cooler_d = (state_d == S_COOL);
    fan_d    = (state_d == S_PRE) || (state_d == S_HEAT) ||
               (state_d == S_COOL) || (state_d == S_POST);
    busy_d   = (state_d != S_IDLE);
    fault_d  = heat_req & cool_req;
  end

  assign heater_en = heater_q;
  assign cooler_en = cooler_q;
  assign fan_en    = fan_q;
  assign busy      = busy_q;
  assign fault     = fault_q;
  assign state     = state_q;

endmodule

// File: tb/tb_ac_sequencer.sv
// Directed bench for ac_sequencer: a vector table of per-cycle inputs and expected state/fault,
// plus hand-written sequences for the mode swap and mid-HEAT reset.
module tb_ac_sequencer;

  logic       clk = 1'b0;
  logic       rst, heat_req, cool_req;
  logic       heater_en, cooler_en, fan_en, busy, fault;
  logic [2:0] state;

  ac_sequencer #(.FAN_PRE(2), .MIN_ON(4), .FAN_POST(3), .MIN_OFF(5), .CW(8)) dut (
    .clk(clk), .rst(rst), .heat_req(heat_req), .cool_req(cool_req),
    .heater_en(heater_en), .cooler_en(cooler_en), .fan_en(fan_en),
    .busy(busy), .fault(fault), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       heat;
    logic       cool;
    logic [2:0] st;   // expected state after the edge that samples these inputs
    logic       flt;  // expected fault after that edge
  } vec_t;

  vec_t tbl[$];
  int   errors = 0;
  int   checks = 0;

  task automatic add(input int n, input logic r, input logic h, input logic c,
                     input logic [2:0] st, input logic f);
    vec_t v;
    v.rst = r; v.heat = h; v.cool = c; v.st = st; v.flt = f;
    for (int i = 0; i < n; i++) tbl.push_back(v);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, sample 1 time unit after the edge, check the drive invariants.
  task automatic step(input logic r, input logic h, input logic c);
    rst = r; heat_req = h; cool_req = c;
    @(posedge clk);
    #1;
    chk("inv_heat_and_cool", int'(heater_en & cooler_en), 0);
    chk("inv_drive_without_fan", int'((heater_en | cooler_en) & ~fan_en), 0);
  endtask

  function automatic int dwell_budget();
    return 40;
  endfunction

  initial begin
    int n;
    rst = 1'b1; heat_req = 1'b0; cool_req = 1'b0;

    // Reset
    add(2, 1, 0, 0, 0, 0);
    // Heat held 20 cycles; both requests high during POST only raise fault
    add(2, 0, 1, 0, 1, 0);
    add(18, 0, 1, 0, 2, 0);
    add(1, 0, 0, 0, 4, 0);
    add(1, 0, 1, 1, 4, 1);
    add(1, 0, 0, 0, 4, 0);
    add(5, 0, 0, 0, 5, 0);
    add(2, 0, 0, 0, 0, 0);
    // Cool 1-cycle pulse aborts PRE, immediate restart allowed
    add(1, 0, 0, 1, 1, 0);
    add(1, 0, 0, 0, 0, 0);
    add(1, 0, 0, 1, 1, 0);
    add(2, 0, 0, 0, 0, 0);
    // Heat dropped as heater rises: MIN_ON/POST/LOCK = 4/3/5; cool during LOCK waits for IDLE
    add(2, 0, 1, 0, 1, 0);
    add(1, 0, 1, 0, 2, 0);
    add(3, 0, 0, 0, 2, 0);
    add(3, 0, 0, 0, 4, 0);
    add(1, 0, 0, 0, 5, 0);
    add(4, 0, 0, 1, 5, 0);
    add(1, 0, 0, 1, 0, 0);
    add(2, 0, 0, 1, 1, 0);
    add(1, 0, 0, 1, 3, 0);
    add(3, 0, 0, 0, 3, 0);
    add(3, 0, 0, 0, 4, 0);
    add(5, 0, 0, 0, 5, 0);
    add(1, 0, 0, 0, 0, 0);
    // Both requests from IDLE: fault for 3 cycles, no start
    add(3, 0, 1, 1, 0, 1);
    add(1, 0, 0, 0, 0, 0);
    // Fault during PRE counts as losing the request
    add(1, 0, 1, 0, 1, 0);
    add(1, 0, 1, 1, 0, 1);
    add(1, 0, 0, 0, 0, 0);

    foreach (tbl[i]) begin
      vec_t v;
      logic [2:0] s;
      v = tbl[i];
      s = v.st;
      step(v.rst, v.heat, v.cool);
      chk($sformatf("v%0d_state", i), int'(state), int'(s));
      chk($sformatf("v%0d_heater", i), int'(heater_en), int'(s == 3'd2));
      chk($sformatf("v%0d_cooler", i), int'(cooler_en), int'(s == 3'd3));
      chk($sformatf("v%0d_fan", i), int'(fan_en), int'(s >= 3'd1 && s <= 3'd4));
      chk($sformatf("v%0d_busy", i), int'(busy), int'(s != 3'd0));
      chk($sformatf("v%0d_fault", i), int'(fault), int'(v.flt));
    end

    // Mode swap in HEAT after 6 heater cycles
    n = 0;
    while (!heater_en && n < 10) begin step(0, 1, 0); n++; end
    chk("swap_heater_started", int'(heater_en), 1);
    for (int i = 0; i < 5; i++) step(0, 1, 0);
    chk("swap_still_heating", int'(state), 2);
    step(0, 0, 1);
    chk("swap_enter_post", int'(state), 4);
    n = 0;
    while (state == 3'd4 && n < dwell_budget()) begin n++; step(0, 0, 1); end
    chk("swap_post_len", n, 3);
    chk("swap_enter_lock", int'(state), 5);
    n = 0;
    while (state == 3'd5 && n < dwell_budget()) begin
      chk("swap_lock_fan_off", int'(fan_en), 0);
      n++; step(0, 0, 1);
    end
    chk("swap_lock_len", n, 5);
    chk("swap_idle", int'(state), 0);
    n = 0;
    while (!cooler_en && n < 20) begin n++; step(0, 0, 1); end
    chk("swap_cooler_delay", n, 3);
    n = 0;
    while (state != 3'd0 && n < dwell_budget()) begin n++; step(0, 0, 0); end
    chk("swap_back_idle", int'(state), 0);

    // Reset pulsed in HEAT, held heat restarts PRE right after release
    n = 0;
    while (state != 3'd2 && n < 10) begin n++; step(0, 1, 0); end
    chk("rst_reached_heat", int'(state), 2);
    step(1, 1, 0);
    chk("rst_state", int'(state), 0);
    chk("rst_outputs", int'({heater_en, cooler_en, fan_en, busy, fault}), 0);
    step(0, 1, 0);
    chk("rst_restart_state", int'(state), 1);
    chk("rst_restart_fan", int'(fan_en), 1);
    step(1, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
